// File: rtl/sort_oets_n.sv
// Sequential odd-even transposition sorter for N unsigned WIDTH-bit elements.
// A packed vector is latched on an input handshake, one compare/swap phase is
// applied per clock, and the sorted vector is held until the consumer accepts it.
// Optional early exit leaves the sort once two consecutive phases make no swap.
module sort_oets_n #(
    parameter int WIDTH      = 3,
    parameter int N          = 3,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic                 busy
);

    // Phase counter only needs to reach N-1.
    localparam int              PW         = (N > 2) ? $clog2(N) : 1;
    localparam logic [PW-1:0]   LAST_PHASE = PW'(N - 1);
    localparam logic            EE_ON      = (EARLY_EXIT != 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N*WIDTH-1:0]   data_q, data_d;
    logic                 desc_q, desc_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic                 quiet_q, quiet_d;      // previous phase made no swap
    logic                 in_ready_q, out_valid_q, busy_q;

    logic [N*WIDTH-1:0]   phase_data_s;
    logic [N-2:0]         pair_swap_s;
    logic                 swapped_s;
    logic                 finish_s;

    // True when element a (lower index) and b must trade places for the mode.
    // Equal values never swap, which keeps the sort stable.
    function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             desc);
        return desc ? (a < b) : (a > b);
    endfunction

    // One transposition phase: even phase pairs (0,1),(2,3)..; odd phase (1,2),(3,4)..
    always_comb begin
        phase_data_s = data_q;
        pair_swap_s  = {(N-1){1'b0}};
        swapped_s    = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            pair_swap_s[i] = (1'(i) == phase_q[0]) &&
                             out_of_order(data_q[i*WIDTH +: WIDTH],
                                          data_q[(i+1)*WIDTH +: WIDTH], desc_q);
            phase_data_s[i*WIDTH +: WIDTH]     = pair_swap_s[i] ? data_q[(i+1)*WIDTH +: WIDTH]
                                                                : phase_data_s[i*WIDTH +: WIDTH];
            phase_data_s[(i+1)*WIDTH +: WIDTH] = pair_swap_s[i] ? data_q[i*WIDTH +: WIDTH]
                                                                : phase_data_s[(i+1)*WIDTH +: WIDTH];
            swapped_s = swapped_s | pair_swap_s[i];
        end
    end

    // Next-state logic for the IDLE -> SORT -> DONE sequencer and its datapath.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        desc_d   = desc_q;
        phase_d  = phase_q;
        quiet_d  = quiet_q;
        finish_s = (phase_q == LAST_PHASE) ||
                   (EE_ON && (phase_q != {PW{1'b0}}) && quiet_q && !swapped_s);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    desc_d  = in_desc;
                    phase_d = {PW{1'b0}};
                    quiet_d = 1'b0;
                    state_d = ST_SORT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SORT: begin
                data_d  = phase_data_s;
                phase_d = phase_q + PW'(1);
                quiet_d = !swapped_s;
                if (finish_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SORT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= {(N*WIDTH){1'b0}};
            desc_q      <= 1'b0;
            phase_q     <= {PW{1'b0}};
            quiet_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            desc_q      <= desc_d;
            phase_q     <= phase_d;
            quiet_q     <= quiet_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_SORT);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_sort_oets_n.sv
// Bench for sort_oets_n: four configurations share one clock and reset.
// Results are compared against a reference that simply sorts the unpacked
// elements with queue sort/rsort.
module tb_sort_oets_n;

    // Instance configs: 0: W3 N3 EE1, 1: W8 N8 EE0, 2: W8 N8 EE1, 3: W3 N4 EE1
    localparam int NK[4] = '{3, 8, 8, 4};
    localparam int WK[4] = '{3, 8, 8, 3};

    logic        clk;
    logic        rst;
    logic        in_valid [4];
    logic        in_desc  [4];
    logic        out_ready[4];
    logic [63:0] in_data  [4];
    logic        in_ready_w [4];
    logic        out_valid_w[4];
    logic        busy_w     [4];
    logic [8:0]  od0;
    logic [63:0] od1;
    logic [63:0] od2;
    logic [11:0] od3;

    int n_vec;
    int n_cmp;
    int n_err;

    sort_oets_n #(.WIDTH(3), .N(3), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .in_data(in_data[0][8:0]), .in_desc(in_desc[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .out_data(od0), .busy(busy_w[0]));
    sort_oets_n #(.WIDTH(8), .N(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .in_data(in_data[1]), .in_desc(in_desc[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .out_data(od1), .busy(busy_w[1]));
    sort_oets_n #(.WIDTH(8), .N(8), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .in_data(in_data[2]), .in_desc(in_desc[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .out_data(od2), .busy(busy_w[2]));
    sort_oets_n #(.WIDTH(3), .N(4), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready_w[3]),
        .in_data(in_data[3][11:0]), .in_desc(in_desc[3]), .out_valid(out_valid_w[3]),
        .out_ready(out_ready[3]), .out_data(od3), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] get_out(input int k);
        case (k)
            0:       return 64'(od0);
            1:       return od1;
            2:       return od2;
            default: return 64'(od3);
        endcase
    endfunction

    // Reference: unpack, sort values, repack (elem0 smallest for asc, largest for desc).
    function automatic logic [63:0] model(input int k, input logic [63:0] d, input logic dsc);
        int          q[$];
        int          w;
        logic [63:0] r;
        w = WK[k];
        for (int i = 0; i < NK[k]; i++)
            q.push_back(int'((d >> (i * w)) & ((64'd1 << w) - 64'd1)));
        if (dsc) q.rsort();
        else     q.sort();
        r = 64'd0;
        for (int i = 0; i < NK[k]; i++)
            r = r | (64'(q[i]) << (i * w));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load one vector, measure latency, check result and the release handshake.
    // exp_lat = 0 means only the 2..N range is checked.
    task automatic run(input int k, input logic [63:0] d, input logic dsc, input int exp_lat);
        int          lat;
        logic [63:0] exp;
        exp = model(k, d, dsc);
        chk("in_ready_before_load", 64'(in_ready_w[k]), 64'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_desc[k]  = dsc;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;
        in_desc[k]  = ~dsc;
        chk("busy_after_load", 64'(busy_w[k]), 64'd1);
        chk("in_ready_after_load", 64'(in_ready_w[k]), 64'd0);
        lat = 0;
        while (!out_valid_w[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_rises", 64'(out_valid_w[k]), 64'd1);
        if (exp_lat != 0) chk("latency", 64'(lat), 64'(exp_lat));
        else chk("latency_range", 64'((lat >= 2) && (lat <= NK[k])), 64'd1);
        chk("sorted_data", get_out(k), exp);
        @(posedge clk); #1;
        chk("out_valid_released", 64'(out_valid_w[k]), 64'd0);
        chk("in_ready_returns", 64'(in_ready_w[k]), 64'd1);
        n_vec++;
    endtask

    initial begin
        logic [63:0] rev8;
        logic [63:0] asc8;
        logic [63:0] d;
        logic [63:0] held;
        n_vec = 0;
        n_cmp = 0;
        n_err = 0;
        rev8  = 64'd0;
        asc8  = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rev8 = rev8 | (64'(7 - i) << (8 * i));
            asc8 = asc8 | (64'(i) << (8 * i));
        end
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_desc[k]   = 1'b0;
            out_ready[k] = 1'b1;
            in_data[k]   = 64'd0;
        end

        // Reset state of every instance
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_in_ready", 64'(in_ready_w[k]), 64'd1);
            chk("reset_out_valid", 64'(out_valid_w[k]), 64'd0);
            chk("reset_busy", 64'(busy_w[k]), 64'd0);
            chk("reset_out_data", get_out(k), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // All 512 three-element 3-bit inputs, ascending
        for (int v = 0; v < 512; v++) run(0, 64'(v), 1'b0, 0);

        // Reverse input without early exit: exactly N phases
        run(1, rev8, 1'b0, 8);

        // Already-sorted input with early exit: two phases; then descending
        run(2, asc8, 1'b0, 2);
        run(2, asc8, 1'b1, 0);

        // Backpressure with duplicates, descending, ignored in_valid pulses
        out_ready[3] = 1'b0;
        d = {52'd0, 3'd5, 3'd2, 3'd5, 3'd5};
        in_valid[3] = 1'b1;
        in_data[3]  = d;
        in_desc[3]  = 1'b1;
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        in_desc[3]  = 1'b0;
        for (int c = 0; c < 10 && !out_valid_w[3]; c++) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid", 64'(out_valid_w[3]), 64'd1);
        held = {52'd0, 3'd2, 3'd5, 3'd5, 3'd5};
        chk("bp_data", get_out(3), held);
        chk("bp_model_agrees", model(3, d, 1'b1), get_out(3));
        for (int c = 0; c < 6; c++) begin
            in_valid[3] = c[0];
            in_data[3]  = 64'($urandom);
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(out_valid_w[3]), 64'd1);
            chk("bp_hold_data", get_out(3), held);
            chk("bp_in_ready_low", 64'(in_ready_w[3]), 64'd0);
        end
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid_w[3]), 64'd0);
        chk("bp_release_ready", 64'(in_ready_w[3]), 64'd1);
        n_vec++;

        // Reset during phase 1 of an N=8 sort aborts it
        in_valid[2] = 1'b1;
        in_data[2]  = rev8;
        in_desc[2]  = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid_w[2]), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_w[2]), 64'd1);
        chk("midrst_busy", 64'(busy_w[2]), 64'd0);
        chk("midrst_out_data", get_out(2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(2, rev8, 1'b0, 0);

        // Back-to-back random loads on every configuration
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 4; k++) begin
                d = {$urandom, $urandom};
                run(k, d, 1'($urandom_range(1, 0)), (k == 1) ? 8 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
